// File: rtl/fp8_pkg.sv
// fp8_pkg: FP8 and BF16 format constants shared by the encode and decode directions
// Contents: exponent biases, special-exponent codes, canonical quiet-NaN mantissa, lane width
package fp8_pkg;
    localparam int          FP8_W            = 8;
    localparam int          FP8_EXP_BIAS     = 8;
    localparam int          BF16_EXP_BIAS    = 127;
    localparam logic [3:0]  FP8_EXP_SPECIAL  = 4'hF;
    localparam logic [7:0]  BF16_EXP_SPECIAL = 8'hFF;
    localparam logic [6:0]  BF16_QNAN_MANT   = 7'h40;
    localparam logic [7:0]  EXP_ADJ          = 8'(BF16_EXP_BIAS - FP8_EXP_BIAS);
endpackage

// File: rtl/fp8_to_bf16_unpack_if.sv
// fp8_to_bf16_unpack_if: packed-FP8 input stream and BF16 output stream with valid/ready
// Signals: in_valid/in_ready/in_data/in_count/in_last, out_valid/out_ready/out_data/out_last
// Modports: master drives the input word and out_ready, slave is the decoder
interface fp8_to_bf16_unpack_if #(
    parameter int LANES = 4,
    parameter int CW    = $clog2(LANES) + 1
);
    logic               in_valid;
    logic               in_ready;
    logic [8*LANES-1:0] in_data;
    logic [CW-1:0]      in_count;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [15:0]        out_data;
    logic               out_last;
    modport master (
        output in_valid, in_data, in_count, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
    modport slave (
        input  in_valid, in_data, in_count, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/fp8_to_bf16_lane.sv
// fp8_to_bf16_lane: exact combinational decode of one FP8 code into BF16
// Ports: i_fp8 (sign[7], exponent[6:3], mantissa[2:0]), o_bf16 (decoded value)
module fp8_to_bf16_lane
    import fp8_pkg::*;
(
    input  logic [7:0]  i_fp8,
    output logic [15:0] o_bf16
);
    logic       w_s;
    logic [3:0] w_e;
    logic [2:0] w_m;
    assign w_s = i_fp8[7];
    assign w_e = i_fp8[6:3];
    assign w_m = i_fp8[2:0];
    // Subnormals normalise by the position of the leading mantissa one,
    // which lowers the rebased exponent by 0, 1 or 2.
    always_comb begin
        o_bf16 = (w_e == FP8_EXP_SPECIAL) ? {w_s, BF16_EXP_SPECIAL, (w_m == 3'd0) ? 7'h00 : BF16_QNAN_MANT}
               : (w_e != 4'd0)            ? {w_s, {4'b0, w_e} + EXP_ADJ, w_m, 4'b0}
               : w_m[2]                   ? {w_s, EXP_ADJ, w_m[1:0], 5'b0}
               : w_m[1]                   ? {w_s, EXP_ADJ - 8'd1, w_m[0], 6'b0}
               : w_m[0]                   ? {w_s, EXP_ADJ - 8'd2, 7'b0}
               :                            {w_s, 15'h0};
    end
endmodule

// File: rtl/fp8_to_bf16_unpack.sv
// fp8_to_bf16_unpack: streams packed FP8 words out as one BF16 value per cycle
// Ports: clk, rst (sync, active high), bus (slave side of fp8_to_bf16_unpack_if)
module fp8_to_bf16_unpack
    import fp8_pkg::*;
#(
    parameter int LANES = 4,
    parameter int CW    = $clog2(LANES) + 1
) (
    input logic                 clk,
    input logic                 rst,
    fp8_to_bf16_unpack_if.slave bus
);
    localparam int IW = $clog2(LANES);
    logic                        r_a_valid;
    logic [LANES-1:0][FP8_W-1:0] r_word;
    logic [CW-1:0]               r_count;
    logic                        r_a_last;
    logic [IW-1:0]               r_idx;
    logic                        r_out_valid;
    logic [15:0]                 r_out_data;
    logic                        r_out_last;
    logic                        w_at_end;
    logic                        w_b_load;
    logic                        w_in_fire;
    logic [FP8_W-1:0]            w_lane;
    logic [15:0]                 w_bf16;
    assign w_at_end  = CW'(r_idx) == r_count - CW'(1);
    assign w_b_load  = r_a_valid && (!r_out_valid || bus.out_ready);
    // Ready while the last lane moves to the output, so words chain without a bubble.
    assign bus.in_ready = !r_a_valid || (w_b_load && w_at_end);
    assign w_in_fire = bus.in_valid && bus.in_ready;
    assign w_lane    = r_word[r_idx];
    fp8_to_bf16_lane u_lane (
        .i_fp8  (w_lane),
        .o_bf16 (w_bf16)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_valid   <= 1'b0;
            r_word      <= '0;
            r_count     <= '0;
            r_a_last    <= 1'b0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= 16'h0000;
            r_out_last  <= 1'b0;
        end else begin
            if (w_b_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_bf16;
                r_out_last  <= r_a_last && w_at_end;
                r_idx       <= w_at_end ? '0 : r_idx + IW'(1);
                if (w_at_end) r_a_valid <= 1'b0;
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            // A new word can only arrive once the held word has finished, so it overrides.
            if (w_in_fire) begin
                r_a_valid <= 1'b1;
                r_word    <= bus.in_data;
                r_count   <= bus.in_count;
                r_a_last  <= bus.in_last;
                r_idx     <= '0;
            end
        end
    end
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
endmodule
